// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port memory; one access at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic            req0_write,
   input  logic [XLEN-1:0] req0_addr,
   input  logic [XLEN-1:0] req0_wdata,
   input  logic [1:0]      req0_wwidth,
   output logic            req0_ready,
   output logic            req0_rvalid,
   output logic [XLEN-1:0] req0_rdata,
   input  logic            req1_valid,
   input  logic            req1_write,
   input  logic [XLEN-1:0] req1_addr,
   input  logic [XLEN-1:0] req1_wdata,
   input  logic [1:0]      req1_wwidth,
   output logic            req1_ready,
   output logic            req1_rvalid,
   output logic [XLEN-1:0] req1_rdata,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_wenable,
   output logic [XLEN-1:0] mem_wdata,
   output logic [1:0]      mem_wwidth,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
   // cnt holds the hold cycles still owed after the first READ cycle
   localparam logic [CW-1:0] CNT_LOAD =
      (READ_LATENCY > 0) ? CW'(READ_LATENCY - 1) : '0;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_READ = 1'b1;

   logic [0:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] addr_q;
   logic            owner_q;
   logic [XLEN-1:0] rdata0_q;
   logic [XLEN-1:0] rdata1_q;
   logic            rvalid0_q;
   logic            rvalid1_q;

   logic            any_valid;
   logic            accept;
   logic            sel1;
   logic            w_write;
   logic [XLEN-1:0] w_addr;
   logic [XLEN-1:0] w_wdata;
   logic [1:0]      w_wwidth;
   logic            cap_en;
   logic            cap_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   assign sel1 = req1_valid & (~req0_valid | ~last_grant);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= sel1;
      end
   end
`else
   assign sel1 = req1_valid & ~req0_valid;
`endif

   assign any_valid  = req0_valid | req1_valid;
   assign accept     = reset & (state == S_IDLE) & any_valid;
   assign req0_ready = accept & ~sel1;
   assign req1_ready = accept & sel1;

   always_comb begin
      w_write  = req0_write;
      w_addr   = req0_addr;
      w_wdata  = req0_wdata;
      w_wwidth = req0_wwidth;
      if (sel1) begin
         w_write  = req1_write;
         w_addr   = req1_addr;
         w_wdata  = req1_wdata;
         w_wwidth = req1_wwidth;
      end
   end

   always_comb begin
      mem_addr    = '0;
      mem_wenable = 1'b0;
      mem_wdata   = '0;
      mem_wwidth  = '0;
      if (accept) begin
         mem_addr    = w_addr;
         mem_wenable = w_write;
         mem_wdata   = w_wdata;
         mem_wwidth  = w_wwidth;
      end else if (reset && state == S_READ) begin
         mem_addr = addr_q;
      end
   end

   // Zero latency captures straight out of the accept cycle
   always_comb begin
      cap_en    = 1'b0;
      cap_owner = owner_q;
      unique case (1'b1)
         (state == S_READ): begin
            cap_en = (cnt == '0);
         end
         (state == S_IDLE): begin
            cap_en    = (READ_LATENCY == 0) & accept & ~w_write;
            cap_owner = sel1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         owner_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && !w_write) begin
                  addr_q  <= w_addr;
                  owner_q <= sel1;
                  if (READ_LATENCY != 0) begin
                     cnt   <= CNT_LOAD;
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= cap_en & ~cap_owner;
         rvalid1_q <= cap_en & cap_owner;
         if (cap_en && !cap_owner) begin
            rdata0_q <= mem_rdata;
         end
         if (cap_en && cap_owner) begin
            rdata1_q <= mem_rdata;
         end
      end
   end

   assign req0_rvalid = rvalid0_q;
   assign req1_rvalid = rvalid1_q;
   assign req0_rdata  = rdata0_q;
   assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: grant table, directed corner sequences and a
// randomized run against a transaction-level model with a local memory.
module tb_mem_arbiter;

   localparam int XLEN = 32;
   localparam int RL   = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            req0_valid, req0_write, req0_ready, req0_rvalid;
   logic [31:0]     req0_addr, req0_wdata, req0_rdata;
   logic [1:0]      req0_wwidth;
   logic            req1_valid, req1_write, req1_ready, req1_rvalid;
   logic [31:0]     req1_addr, req1_wdata, req1_rdata;
   logic [1:0]      req1_wwidth;
   logic [31:0]     mem_addr, mem_wdata, mem_rdata;
   logic            mem_wenable;
   logic [1:0]      mem_wwidth;

   int total  = 0;
   int passed = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.XLEN(XLEN), .READ_LATENCY(RL)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_wwidth(req0_wwidth), .req0_ready(req0_ready),
      .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_wwidth(req1_wwidth), .req1_ready(req1_ready),
      .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
      .mem_addr(mem_addr), .mem_wenable(mem_wenable),
      .mem_wdata(mem_wdata), .mem_wwidth(mem_wwidth),
      .mem_rdata(mem_rdata)
   );

   // Memory: 64 words, combinational read, byte-lane writes
   logic [31:0] mem [0:63];

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      return {i[15:0], 16'hC0DE};
   endfunction

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (mem_wenable) begin
         case (mem_wwidth)
            2'd0: mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
            2'd1: mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
            default: mem[mem_addr[7:2]] <= mem_wdata;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %h required %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_wwidth = 0;
      req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_wwidth = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   typedef struct {
      logic v0; logic w0; logic [31:0] a0;
      logic v1; logic w1; logic [31:0] a1; logic [1:0] ww1;
      logic er0; logic er1; logic ewe; logic [31:0] ea; logic [1:0] ew;
   } vec_t;

   vec_t vecs[6];

   // Random-phase state
   logic        rv [2];
   logic        rw [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];
   logic [1:0]  rwid [2];
   logic        acc [2];

   int          grants[$];
   int          exp_g [4];
   int          we_cnt;
   int          waited;

   initial begin
      vecs[0] = '{0, 0, 32'h0,  0, 0, 32'h0,  2'd0, 0, 0, 0, 32'h0,  2'd0};
      vecs[1] = '{1, 0, 32'h40, 0, 0, 32'h0,  2'd0, 1, 0, 0, 32'h40, 2'd2};
      vecs[2] = '{0, 0, 32'h0,  1, 1, 32'h44, 2'd0, 0, 1, 1, 32'h44, 2'd0};
      vecs[3] = '{1, 1, 32'h48, 1, 0, 32'h4C, 2'd1, 1, 0, 1, 32'h48, 2'd2};
      vecs[4] = '{1, 0, 32'h40, 1, 0, 32'h4C, 2'd1, 1, 0, 0, 32'h40, 2'd2};
      vecs[5] = '{0, 0, 32'h0,  1, 0, 32'h50, 2'd1, 0, 1, 0, 32'h50, 2'd1};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif

      // Reset state, with requests present to check output forcing
      clear_inputs();
      req0_valid = 1; req0_write = 1; req0_addr = 32'h8; req0_wwidth = 2;
      req1_valid = 1; req1_addr = 32'hC;
      tick();
      tick();
      @(negedge clock);
      chk("rst_ready0", {31'b0, req0_ready}, 0);
      chk("rst_ready1", {31'b0, req1_ready}, 0);
      chk("rst_wen", {31'b0, mem_wenable}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rvalid", {30'b0, req1_rvalid, req0_rvalid}, 0);
      chk("rst_rdata0", req0_rdata, 0);
      chk("rst_rdata1", req1_rdata, 0);
      clear_inputs();
      tick();
      reset = 1'b1;

      // Single-cycle grant table in IDLE; valids drop before the edge
      for (int i = 0; i < 6; i++) begin
         req0_valid = vecs[i].v0; req0_write = vecs[i].w0;
         req0_addr = vecs[i].a0; req0_wdata = 32'h1111_0000; req0_wwidth = 2;
         req1_valid = vecs[i].v1; req1_write = vecs[i].w1;
         req1_addr = vecs[i].a1; req1_wdata = 32'h2222_0000; req1_wwidth = vecs[i].ww1;
         @(negedge clock);
         chk($sformatf("vec%0d_ready0", i), {31'b0, req0_ready}, {31'b0, vecs[i].er0});
         chk($sformatf("vec%0d_ready1", i), {31'b0, req1_ready}, {31'b0, vecs[i].er1});
         chk($sformatf("vec%0d_wen", i), {31'b0, mem_wenable}, {31'b0, vecs[i].ewe});
         chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].ea);
         chk($sformatf("vec%0d_wwidth", i), {30'b0, mem_wwidth}, {30'b0, vecs[i].ew});
         clear_inputs();
         tick();
      end

      // Port 0 single read of 0x10
      req0_valid = 1; req0_addr = 32'h10;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clock);
         chk($sformatf("rd_c%0d_ready0", c), {31'b0, req0_ready}, (c == 0) ? 1 : 0);
         if (c <= RL) chk($sformatf("rd_c%0d_addr", c), mem_addr, 32'h10);
         chk($sformatf("rd_c%0d_rvalid0", c), {31'b0, req0_rvalid}, (c == RL + 1) ? 1 : 0);
         if (c > RL) chk($sformatf("rd_c%0d_rdata0", c), req0_rdata, 32'hDEAD_BEEF);
         tick();
         req0_valid = 0;
      end

      // Port 1 write, then port 0 reads it back
      we_cnt = 0;
      req1_valid = 1; req1_write = 1; req1_addr = 32'h20;
      req1_wdata = 32'h1234_5678; req1_wwidth = 2;
      @(negedge clock);
      chk("wr_ready1", {31'b0, req1_ready}, 1);
      if (mem_wenable) we_cnt++;
      tick();
      clear_inputs();
      req0_valid = 1; req0_addr = 32'h20;
      waited = 0;
      @(negedge clock);
      chk("wr_rd_ready0", {31'b0, req0_ready}, 1);
      while (!req0_rvalid && waited < 10) begin
         if (mem_wenable) we_cnt++;
         tick();
         req0_valid = 0;
         @(negedge clock);
         waited++;
      end
      chk("wr_rd_rvalid_wait", waited, RL + 1);
      chk("wr_rd_rdata0", req0_rdata, 32'h1234_5678);
      chk("wr_wen_cycles", we_cnt, 1);
      tick();

      // Port 1 write arrives during a port 0 read
      req0_valid = 1; req0_addr = 32'h30;
      @(negedge clock);
      chk("blk_c0_ready0", {31'b0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_write = 1; req1_addr = 32'h34;
      req1_wdata = 32'hAA55_AA55; req1_wwidth = 2;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         chk($sformatf("blk_c%0d_ready1", c), {31'b0, req1_ready}, (c == 3) ? 1 : 0);
         chk($sformatf("blk_c%0d_wen", c), {31'b0, mem_wenable}, (c == 3) ? 1 : 0);
         if (c < 3) chk($sformatf("blk_c%0d_addr", c), mem_addr, 32'h30);
         else chk("blk_c3_addr", mem_addr, 32'h34);
         if (c == 3) chk("blk_c3_rvalid0", {31'b0, req0_rvalid}, 1);
         tick();
      end
      clear_inputs();
      @(negedge clock);
      chk("blk_mem", mem[13], 32'hAA55_AA55);
      tick();

      // Reset pulled low in cycle 1 of a read
      req0_valid = 1; req0_addr = 32'h10;
      @(negedge clock);
      chk("rmid_c0_ready0", {31'b0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      reset = 1'b0;
      req1_valid = 1; req1_write = 1; req1_addr = 32'h38; req1_wdata = 32'hFFFF_FFFF;
      req1_wwidth = 2;
      @(negedge clock);
      chk("rmid_ready1", {31'b0, req1_ready}, 0);
      chk("rmid_wen", {31'b0, mem_wenable}, 0);
      chk("rmid_addr", mem_addr, 0);
      chk("rmid_wdata", mem_wdata, 0);
      chk("rmid_rdata0", req0_rdata, 0);
      tick();
      tick();
      clear_inputs();
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk($sformatf("rmid_post%0d_rvalid", c), {30'b0, req1_rvalid, req0_rvalid}, 0);
         tick();
      end
      req0_valid = 1; req0_addr = 32'h10;
      @(negedge clock);
      chk("rmid_new_ready0", {31'b0, req0_ready}, 1);
      tick();
      req0_valid = 0;
      tick();
      tick();
      @(negedge clock);
      chk("rmid_new_rvalid0", {31'b0, req0_rvalid}, 1);
      chk("rmid_new_rdata0", req0_rdata, 32'hDEAD_BEEF);
      tick();

      // Simultaneous reads, port 0 drops after its grant
      do_reset();
      req0_valid = 1; req0_addr = 32'h40;
      req1_valid = 1; req1_addr = 32'h44;
      @(negedge clock);
      chk("sim_c0_ready0", {31'b0, req0_ready}, 1);
      chk("sim_c0_ready1", {31'b0, req1_ready}, 0);
      tick();
      req0_valid = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         chk($sformatf("sim_c%0d_ready1", c), {31'b0, req1_ready}, (c == 3) ? 1 : 0);
         if (c == 3) chk("sim_c3_rvalid0", {31'b0, req0_rvalid}, 1);
         tick();
      end
      req1_valid = 0;
      tick();
      tick();
      @(negedge clock);
      chk("sim_rvalid1", {31'b0, req1_rvalid}, 1);
      chk("sim_rdata1", req1_rdata, init_word(17));
      tick();

      // Both ports continuously re-requesting reads
      do_reset();
      req0_valid = 1; req0_addr = 32'h40;
      req1_valid = 1; req1_addr = 32'h44;
      grants.delete();
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
         @(negedge clock);
         if (req0_ready && req1_ready) chk("dual_grant", 1, 0);
         else if (req0_ready) grants.push_back(0);
         else if (req1_ready) grants.push_back(1);
         tick();
      end
      chk("grant_count", grants.size(), 4);
      for (int k = 0; k < 4 && k < grants.size(); k++)
         chk($sformatf("grant%0d", k), grants[k], exp_g[k]);
      clear_inputs();
      repeat (RL + 2) tick();

      // Randomized run against a transaction-level model
      do_reset();
      begin
         int          busy;
         logic        last;
         int          pend_due;
         logic        pend_own;
         logic [31:0] pend_data;
         logic [31:0] hold_addr;
         logic [31:0] exp_rd [2];
         logic        er [2];
         logic        erv [2];
         logic        ewe;
         logic [31:0] ea;
         int          win;
         busy = 0; last = 1; pend_due = -1; pend_own = 0; pend_data = 0;
         hold_addr = 0; exp_rd[0] = 0; exp_rd[1] = 0;
         for (int p = 0; p < 2; p++) begin rv[p] = 0; acc[p] = 0; end
         for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < 2; p++) begin
               if (!rv[p] || acc[p]) begin
                  rv[p]   = ($urandom_range(0, 2) != 0);
                  rw[p]   = $urandom_range(0, 1) == 1;
                  ra[p]   = 32'($urandom_range(0, 255));
                  rd[p]   = $urandom;
                  rwid[p] = 2'($urandom_range(0, 2));
               end
            end
            req0_valid = rv[0]; req0_write = rw[0]; req0_addr = ra[0];
            req0_wdata = rd[0]; req0_wwidth = rwid[0];
            req1_valid = rv[1]; req1_write = rw[1]; req1_addr = ra[1];
            req1_wdata = rd[1]; req1_wwidth = rwid[1];
            @(negedge clock);
            for (int p = 0; p < 2; p++) begin
               erv[p] = (pend_due == cyc) && (pend_own == p[0]);
               if (erv[p]) exp_rd[p] = pend_data;
               er[p] = 0;
            end
            ewe = 0; ea = 0; win = -1;
            if (busy > 0) ea = hold_addr;
            else if (rv[0] || rv[1]) begin
               if (rv[0] && rv[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  win = last ? 0 : 1;
`else
                  win = 0;
`endif
               end else win = rv[1] ? 1 : 0;
               er[win] = 1; ewe = rw[win]; ea = ra[win];
            end
            chk($sformatf("rnd%0d_ready0", cyc), {31'b0, req0_ready}, {31'b0, er[0]});
            chk($sformatf("rnd%0d_ready1", cyc), {31'b0, req1_ready}, {31'b0, er[1]});
            chk($sformatf("rnd%0d_wen", cyc), {31'b0, mem_wenable}, {31'b0, ewe});
            chk($sformatf("rnd%0d_addr", cyc), mem_addr, ea);
            chk($sformatf("rnd%0d_rvalid0", cyc), {31'b0, req0_rvalid}, {31'b0, erv[0]});
            chk($sformatf("rnd%0d_rvalid1", cyc), {31'b0, req1_rvalid}, {31'b0, erv[1]});
            chk($sformatf("rnd%0d_rdata0", cyc), req0_rdata, exp_rd[0]);
            chk($sformatf("rnd%0d_rdata1", cyc), req1_rdata, exp_rd[1]);
            if (win >= 0 && rw[win]) begin
               chk($sformatf("rnd%0d_wdata", cyc), mem_wdata, rd[win]);
               chk($sformatf("rnd%0d_wwidth", cyc), {30'b0, mem_wwidth}, {30'b0, rwid[win]});
            end
            if (busy > 0) busy--;
            acc[0] = er[0]; acc[1] = er[1];
            if (win >= 0) begin
               last = win[0];
               if (!rw[win]) begin
                  busy      = RL;
                  hold_addr = ra[win];
                  pend_due  = cyc + RL + 1;
                  pend_own  = win[0];
                  pend_data = mem[ra[win][7:2]];
               end
            end
            tick();
         end
      end
      clear_inputs();
      repeat (RL + 2) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
